// File: rtl/certificate_chain_sequencer_pkg.sv
// Shared types, result codes and the provisioned certificate constants for the
// certificate-chain sequencer and its compare stage.
package certificate_chain_sequencer_pkg;

  // Payload is the message length with the header fields stripped off.
  localparam int unsigned MSG_LEN                 = 128;
  localparam int unsigned SIZE_OF_HEADER_VARS     = 8;
  localparam int unsigned SIZE_OF_HEADER_IN_BYTES = 8;
  localparam int unsigned CERT_PAYLOAD_W          =
      MSG_LEN - (SIZE_OF_HEADER_VARS * SIZE_OF_HEADER_IN_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCmp,
    StChk,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrBadCert = 2'd1,
    ErrBadSlot = 2'd2,
    ErrTimeout = 2'd3
  } err_code_e;

  localparam logic [1:0] SLOT_INVALID = 2'd3;

  localparam logic [7:0] SLOT0_NUM_CERTS = 8'd6;
  localparam logic [7:0] SLOT1_NUM_CERTS = 8'd4;
  localparam logic [7:0] SLOT2_NUM_CERTS = 8'd5;

  localparam logic [CERT_PAYLOAD_W-1:0] SLOT0_CERT1 = 64'h3C8A_11F0_0A01_5E71;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT0_CERT2 = 64'h7D20_94B3_0A02_C1D8;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT0_CERT3 = 64'hA4E6_2F19_0A03_7B02;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT0_CERT4 = 64'h19B7_C35D_0A04_E6A9;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT0_CERT5 = 64'hE0F2_6A88_0A05_3D14;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT0_CERT6 = 64'h5B61_D7C4_0A06_92FB;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT1_CERT1 = 64'h8C13_4E7A_1B01_0F63;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT1_CERT2 = 64'h2F95_B061_1B02_A8DE;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT1_CERT3 = 64'hD471_39C2_1B03_6B35;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT1_CERT4 = 64'h6AD8_E21F_1B04_F490;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT2_CERT1 = 64'hB35E_0C97_2C01_8A2D;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT2_CERT2 = 64'h41C9_7FA6_2C02_1E7C;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT2_CERT3 = 64'hF70B_A45E_2C03_D3C1;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT2_CERT4 = 64'h0E66_581B_2C04_6F58;
  localparam logic [CERT_PAYLOAD_W-1:0] SLOT2_CERT5 = 64'h9AA2_E3D0_2C05_B7E6;

  typedef struct packed {
    logic                      hit;
    logic [CERT_PAYLOAD_W-1:0] value;
  } cert_lookup_t;

  // Number of certificates provisioned for a slot; 0 for the invalid slot.
  function automatic logic [7:0] num_certs(input logic [1:0] slot);
    logic [7:0] n;
    case (slot)
      2'd0:    n = SLOT0_NUM_CERTS;
      2'd1:    n = SLOT1_NUM_CERTS;
      2'd2:    n = SLOT2_NUM_CERTS;
      default: n = 8'd0;
    endcase
    return n;
  endfunction

  // Reference certificate for (slot, index); hit is low when none is provisioned.
  function automatic cert_lookup_t cert_lookup(input logic [1:0] slot, input logic [7:0] idx);
    cert_lookup_t r;
    r.hit   = 1'b1;
    r.value = '0;
    case ({slot, idx})
      {2'd0, 8'd1}: r.value = SLOT0_CERT1;
      {2'd0, 8'd2}: r.value = SLOT0_CERT2;
      {2'd0, 8'd3}: r.value = SLOT0_CERT3;
      {2'd0, 8'd4}: r.value = SLOT0_CERT4;
      {2'd0, 8'd5}: r.value = SLOT0_CERT5;
      {2'd0, 8'd6}: r.value = SLOT0_CERT6;
      {2'd1, 8'd1}: r.value = SLOT1_CERT1;
      {2'd1, 8'd2}: r.value = SLOT1_CERT2;
      {2'd1, 8'd3}: r.value = SLOT1_CERT3;
      {2'd1, 8'd4}: r.value = SLOT1_CERT4;
      {2'd2, 8'd1}: r.value = SLOT2_CERT1;
      {2'd2, 8'd2}: r.value = SLOT2_CERT2;
      {2'd2, 8'd3}: r.value = SLOT2_CERT3;
      {2'd2, 8'd4}: r.value = SLOT2_CERT4;
      {2'd2, 8'd5}: r.value = SLOT2_CERT5;
      default:      r.hit   = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/certificate_chain_sequencer_cert_cmp.sv
// Compares one registered certificate chunk against the provisioned reference
// for (slot, index). Flags are registered and held low while disabled or in reset.
module certificate_compare
  import certificate_chain_sequencer_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = CERT_PAYLOAD_W
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [1:0]           slot_i,
  input  logic [7:0]           counter_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic                 error_o
);

  cert_lookup_t lk;
  logic         match;
  logic         valid_d, valid_q;
  logic         error_d, error_q;

  // Reference lookup and flag next-state; an unprovisioned index raises neither flag.
  always_comb begin
    lk      = cert_lookup(slot_i, counter_i);
    match   = lk.hit && (payload_i == PAYLOAD_W'(lk.value));
    valid_d = 1'b0;
    error_d = 1'b0;
    if (!reset_i && enable_i) begin
      valid_d = match;
      error_d = lk.hit && !match;
    end
  end

  // Flag registers; synchronous reset so they clear on the first edge.
  always_ff @(posedge clk_i) begin
    valid_q <= valid_d;
    error_q <= error_d;
  end

  assign valid_o = valid_q;
  assign error_o = error_q;

endmodule

// File: rtl/certificate_chain_sequencer.sv
// Walks one certificate chain for a selected slot: takes payload chunks one at a
// time, checks each against the compare stage and reports a single verdict.
module certificate_chain_sequencer
  import certificate_chain_sequencer_pkg::*;
#(
  parameter int unsigned PAYLOAD_W      = CERT_PAYLOAD_W,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TMO_W          = 16
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [1:0]           Slot,
  input  logic                 Chunk_Valid,
  input  logic [PAYLOAD_W-1:0] Chunk_Payload,
  output logic                 Chunk_Ready,
  output logic                 Busy,
  output logic [7:0]           Cert_Index,
  output logic                 Done,
  output logic                 Chain_Valid,
  output logic                 Chain_Error,
  output logic [1:0]           Err_Code
);

  localparam bit               TmoEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TmoLast = TmoEn ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e               state_d, state_q;
  logic [7:0]           idx_d, idx_q;
  logic [1:0]           slot_d, slot_q;
  logic [PAYLOAD_W-1:0] payload_d, payload_q;
  logic [TMO_W-1:0]     tmo_d, tmo_q;
  logic                 chain_valid_d, chain_valid_q;
  logic                 chain_error_d, chain_error_q;
  err_code_e            err_d, err_q;
  logic                 busy_q, ready_q, done_q;

  logic                 cmp_en, cmp_reset, cmp_valid, cmp_error;
  logic [7:0]           n_certs;

  assign cmp_en    = (state_q == StCmp) || (state_q == StChk);
  assign cmp_reset = ~Reset_n;
  assign n_certs   = num_certs(slot_q);

  certificate_compare #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_cert_cmp (
    .clk_i     (clk),
    .reset_i   (cmp_reset),
    .enable_i  (cmp_en),
    .slot_i    (slot_q),
    .counter_i (idx_q),
    .payload_i (payload_q),
    .valid_o   (cmp_valid),
    .error_o   (cmp_error)
  );

  // Next-state: FSM, index, timeout counter and sticky verdict. Abort wins over all.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_d        = slot_q;
    payload_d     = payload_q;
    tmo_d         = tmo_q;
    chain_valid_d = chain_valid_q;
    chain_error_d = chain_error_q;
    err_d         = err_q;
    if (Abort && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          idx_d = '0;
          if (Start && !Abort) begin
            chain_valid_d = 1'b0;
            chain_error_d = 1'b0;
            err_d         = ErrNone;
            if (Slot != SLOT_INVALID) begin
              slot_d  = Slot;
              idx_d   = 8'd1;
              tmo_d   = '0;
              state_d = StWait;
            end else begin
              chain_error_d = 1'b1;
              err_d         = ErrBadSlot;
              state_d       = StDone;
            end
          end
        end
        StWait: begin
          if (Chunk_Valid) begin
            payload_d = Chunk_Payload;
            state_d   = StCmp;
          end else if (TmoEn && (tmo_q == TmoLast)) begin
            chain_error_d = 1'b1;
            err_d         = ErrTimeout;
            state_d       = StDone;
          end else if (TmoEn) begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        StCmp: begin
          state_d = StChk;
        end
        StChk: begin
          if (cmp_valid && !cmp_error && (idx_q == n_certs)) begin
            chain_valid_d = 1'b1;
            state_d       = StDone;
          end else if (cmp_valid && !cmp_error) begin
            idx_d   = idx_q + 8'd1;
            tmo_d   = '0;
            state_d = StWait;
          end else begin
            // Explicit mismatch or no reference for this index.
            chain_error_d = 1'b1;
            err_d         = ErrBadCert;
            state_d       = StDone;
          end
        end
        StDone: begin
          idx_d   = '0;
          state_d = StIdle;
        end
        default: begin
          idx_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      slot_q        <= '0;
      payload_q     <= '0;
      tmo_q         <= '0;
      chain_valid_q <= 1'b0;
      chain_error_q <= 1'b0;
      err_q         <= ErrNone;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slot_q        <= slot_d;
      payload_q     <= payload_d;
      tmo_q         <= tmo_d;
      chain_valid_q <= chain_valid_d;
      chain_error_q <= chain_error_d;
      err_q         <= err_d;
      busy_q        <= (state_d != StIdle);
      ready_q       <= (state_d == StWait);
      done_q        <= (state_d == StDone);
    end
  end

  assign Chunk_Ready = ready_q;
  assign Busy        = busy_q;
  assign Cert_Index  = idx_q;
  assign Done        = done_q;
  assign Chain_Valid = chain_valid_q;
  assign Chain_Error = chain_error_q;
  assign Err_Code    = err_q;

endmodule

// File: tb/tb_certificate_chain_sequencer.sv
// Directed bench for certificate_chain_sequencer: a table of whole-chain runs plus
// hand-written sequences for timeout, busy/abort and asynchronous reset.
module tb_certificate_chain_sequencer;
  import certificate_chain_sequencer_pkg::*;

  localparam int unsigned PW = CERT_PAYLOAD_W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [1:0]    slot;
  logic          chunk_valid;
  logic [PW-1:0] chunk_payload;
  logic          chunk_ready;
  logic          busy;
  logic [7:0]    cert_index;
  logic          done;
  logic          chain_valid;
  logic          chain_error;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  certificate_chain_sequencer #(
    .PAYLOAD_W      (PW),
    .TIMEOUT_CYCLES (16),
    .TMO_W          (16)
  ) dut (
    .clk           (clk),
    .Reset_n       (reset_n),
    .Start         (start),
    .Abort         (abort),
    .Slot          (slot),
    .Chunk_Valid   (chunk_valid),
    .Chunk_Payload (chunk_payload),
    .Chunk_Ready   (chunk_ready),
    .Busy          (busy),
    .Cert_Index    (cert_index),
    .Done          (done),
    .Chain_Valid   (chain_valid),
    .Chain_Error   (chain_error),
    .Err_Code      (err_code)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // Counts Done cycles, sampled mid-cycle.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] tb_cert(input logic [1:0] s, input int k);
    logic [PW-1:0] r;
    r = '0;
    case (s)
      2'd0: case (k)
        1: r = SLOT0_CERT1; 2: r = SLOT0_CERT2; 3: r = SLOT0_CERT3;
        4: r = SLOT0_CERT4; 5: r = SLOT0_CERT5; 6: r = SLOT0_CERT6;
        default: r = '0;
      endcase
      2'd1: case (k)
        1: r = SLOT1_CERT1; 2: r = SLOT1_CERT2; 3: r = SLOT1_CERT3; 4: r = SLOT1_CERT4;
        default: r = '0;
      endcase
      2'd2: case (k)
        1: r = SLOT2_CERT1; 2: r = SLOT2_CERT2; 3: r = SLOT2_CERT3;
        4: r = SLOT2_CERT4; 5: r = SLOT2_CERT5;
        default: r = '0;
      endcase
      default: r = '0;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [1:0] slot;
    int         bad_idx;   // chunk whose LSB is flipped, 0 for none
    int         n_send;
    logic       exp_cv;
    logic       exp_ce;
    logic [1:0] exp_ec;
    logic [7:0] exp_ci;
    int         exp_acc;
    logic       exp_ready;
    int         exp_cyc;   // cycles from first post-Start sample to Done
  } vec_t;

  function automatic vec_t mk(input logic [1:0] s, input int bad, input int n, input logic cv,
                              input logic ce, input logic [1:0] ec, input logic [7:0] ci,
                              input int acc, input logic rdy, input int cyc);
    vec_t v;
    v.slot = s; v.bad_idx = bad; v.n_send = n; v.exp_cv = cv; v.exp_ce = ce; v.exp_ec = ec;
    v.exp_ci = ci; v.exp_acc = acc; v.exp_ready = rdy; v.exp_cyc = cyc;
    return v;
  endfunction

  // Starts a chain and feeds chunks whenever ready, until Done or the cycle budget expires.
  task automatic run_chain(input logic [1:0] s, input int bad_idx, input int n_send,
                           output logic done_seen, output logic ready_seen, output int accepted,
                           output int done_cyc, output logic cv, output logic ce,
                           output logic [1:0] ec, output logic [7:0] ci);
    int            k;
    logic [PW-1:0] p;
    k = 1; done_seen = 1'b0; ready_seen = 1'b0; accepted = 0; done_cyc = -1;
    cv = 1'b0; ce = 1'b0; ec = 2'd0; ci = 8'd0;
    slot = s; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      if (done) begin
        done_seen = 1'b1; done_cyc = cyc;
        cv = chain_valid; ce = chain_error; ec = err_code; ci = cert_index;
      end else if (chunk_ready && k <= n_send) begin
        ready_seen = 1'b1;
        p = tb_cert(s, k);
        if (k == bad_idx) p[0] = ~p[0];
        chunk_payload = p; chunk_valid = 1'b1;
        accepted++; k++;
        tick();
        chunk_valid = 1'b0;
      end else begin
        if (chunk_ready) ready_seen = 1'b1;
        tick();
      end
    end
  endtask

  vec_t       vecs[7];
  logic       d_seen, r_seen, cv, ce;
  logic [1:0] ec;
  logic [7:0] ci;
  int         acc, dcyc, d0, n;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; slot = 2'd0;
    chunk_valid = 1'b0; chunk_payload = '0;

    vecs[0] = mk(2'd0, 0, 6, 1'b1, 1'b0, 2'd0, 8'd6, 6, 1'b1, 18);
    vecs[1] = mk(2'd1, 3, 4, 1'b0, 1'b1, 2'd1, 8'd3, 3, 1'b1, 9);
    vecs[2] = mk(2'd3, 0, 6, 1'b0, 1'b1, 2'd2, 8'd0, 0, 1'b0, 0);
    vecs[3] = mk(2'd1, 0, 4, 1'b1, 1'b0, 2'd0, 8'd4, 4, 1'b1, 12);
    vecs[4] = mk(2'd2, 0, 5, 1'b1, 1'b0, 2'd0, 8'd5, 5, 1'b1, 15);
    vecs[5] = mk(2'd2, 1, 5, 1'b0, 1'b1, 2'd1, 8'd1, 1, 1'b1, 3);
    vecs[6] = mk(2'd0, 6, 6, 1'b0, 1'b1, 2'd1, 8'd6, 6, 1'b1, 18);

    // Reset state
    repeat (3) tick();
    check("rst_outputs", {chunk_ready, busy, cert_index, done, chain_valid, chain_error, err_code},
          14'd0);
    reset_n = 1'b1;
    tick();
    check("idle_outputs", {chunk_ready, busy, cert_index, done}, 11'd0);

    // Table of whole-chain runs
    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt;
      run_chain(vecs[i].slot, vecs[i].bad_idx, vecs[i].n_send, d_seen, r_seen, acc, dcyc,
                cv, ce, ec, ci);
      check($sformatf("v%0d_done", i), d_seen, 1'b1);
      check($sformatf("v%0d_done_cycle", i), dcyc, vecs[i].exp_cyc);
      check($sformatf("v%0d_chain_valid", i), cv, vecs[i].exp_cv);
      check($sformatf("v%0d_chain_error", i), ce, vecs[i].exp_ce);
      check($sformatf("v%0d_err_code", i), ec, vecs[i].exp_ec);
      check($sformatf("v%0d_cert_index", i), ci, vecs[i].exp_ci);
      check($sformatf("v%0d_accepted", i), acc, vecs[i].exp_acc);
      check($sformatf("v%0d_ready_seen", i), r_seen, vecs[i].exp_ready);
      tick();
      check($sformatf("v%0d_done_pulses", i), done_cnt - d0, 1);
      check($sformatf("v%0d_post_idle", i), {done, busy, chunk_ready, cert_index}, 11'd0);
      check($sformatf("v%0d_sticky", i), {chain_valid, chain_error, err_code},
            {vecs[i].exp_cv, vecs[i].exp_ce, vecs[i].exp_ec});
    end

    // Latency per chunk, then timeout after re-entering WAIT
    slot = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("tmo_wait_ready", {chunk_ready, busy, cert_index}, {1'b1, 1'b1, 8'd1});
    chunk_payload = SLOT2_CERT1; chunk_valid = 1'b1;
    tick();
    chunk_valid = 1'b0;
    check("lat_cmp_ready", chunk_ready, 1'b0);
    tick();
    check("lat_chk_ready", chunk_ready, 1'b0);
    tick();
    check("lat_rewait", {chunk_ready, cert_index}, {1'b1, 8'd2});
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 16);
    check("tmo_result", {chain_valid, chain_error, err_code, cert_index},
          {1'b0, 1'b1, 2'd3, 8'd2});
    tick();
    check("tmo_idle", {busy, done}, 2'b00);

    // Start ignored while busy; Abort beats Chunk_Valid
    slot = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chunk_payload = SLOT1_CERT1; chunk_valid = 1'b1;
    tick();
    chunk_valid = 1'b0;
    tick(); tick();
    check("busy_at_idx2", {chunk_ready, cert_index}, {1'b1, 8'd2});
    d0 = done_cnt;
    slot = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", {busy, chunk_ready, cert_index}, {1'b1, 1'b1, 8'd2});
    abort = 1'b1; chunk_valid = 1'b1; chunk_payload = SLOT1_CERT2;
    tick();
    abort = 1'b0; chunk_valid = 1'b0;
    check("abort_idle", {busy, chunk_ready, cert_index, done}, 11'd0);
    tick(); tick(); tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_still_idle", {busy, chunk_ready}, 2'b00);
    check("abort_sticky", {chain_valid, chain_error, err_code}, 4'd0);

    // Asynchronous reset mid-CMP at index 4, then a clean full chain
    slot = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chunk_payload = tb_cert(2'd0, k); chunk_valid = 1'b1;
      tick();
      chunk_valid = 1'b0;
      tick(); tick();
    end
    check("rst_pre_idx4", {chunk_ready, cert_index}, {1'b1, 8'd4});
    chunk_payload = SLOT0_CERT4; chunk_valid = 1'b1;
    tick();
    chunk_valid = 1'b0;
    check("rst_in_cmp", {busy, chunk_ready, cert_index}, {1'b1, 1'b0, 8'd4});
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_clear",
          {chunk_ready, busy, cert_index, done, chain_valid, chain_error, err_code}, 14'd0);
    tick(); tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_chain(2'd0, 0, 6, d_seen, r_seen, acc, dcyc, cv, ce, ec, ci);
    check("rst_rerun_done", d_seen, 1'b1);
    check("rst_rerun_result", {cv, ce, ec, ci}, {1'b1, 1'b0, 2'd0, 8'd6});
    check("rst_rerun_accepted", acc, 6);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
